csr_access_unit: RTL and testbench

- Initiator side of the CPU's CSR port: accepts one decoded Zicsr instruction per handshake from execute and drives the CSR file's rd/wr/set/clr strobes, address and write data.
- Captures the old CSR value and returns it with an rd writeback request.
- Sits between the execute stage and the CSR register file.
- Stalls the pipeline through req_ready / rsp_valid while an access is in flight.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_access_decode.sv | 34 +++
 rtl/csr_access_unit.sv | 168 ++++++++++++++++
 tb/tb_csr_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access path: Zicsr funct3 codes, the
// operation encoding carried in funct3[1:0], the access FSM states and
// the read-only address test.
package csr_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // funct3[1:0] selects the operation; funct3[2] only selects the operand source
  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_RW      = 2'b01,
    OP_RS      = 2'b10,
    OP_RC      = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

  typedef struct packed {
    csr_op_e op;
    logic    do_read;
    logic    do_write;
    logic    illegal;
  } csr_decode_t;

  // The top two address bits equal to 2'b11 mark a read-only CSR
  function automatic logic is_read_only(input logic [11:0] adr);
    return (adr[11:10] == 2'b11);
  endfunction

endpackage

// File: rtl/csr_access_decode.sv
// Combinational Zicsr decode: works out which of read/write an instruction
// performs and whether it must be trapped as illegal. Kept separate so the
// hazard unit can reuse the same decision.
module csr_access_decode
  import csr_pkg::*;
#(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic [1:0]  funct3_op_i,
  input  logic [11:0] adr_i,
  input  logic [4:0]  uimm_i,
  input  logic [4:0]  rd_i,
  output csr_decode_t dec_o
);

  csr_op_e op;
  logic    do_read;
  logic    do_write;

  // A RW into x0 skips the read; RS/RC with a zero source skip the write,
  // and writing a read-only CSR is only an error when a write really happens
  always_comb begin
    op       = csr_op_e'(funct3_op_i);
    do_read  = !((op == OP_RW) && (rd_i == 5'd0));
    do_write = (op == OP_RW) || (uimm_i != 5'd0);
    dec_o          = '0;
    dec_o.op       = op;
    dec_o.do_read  = do_read;
    dec_o.do_write = do_write;
    dec_o.illegal  = (op == OP_ILLEGAL) ||
                     (RO_CHECK && is_read_only(adr_i) && do_write);
  end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR port. Takes one decoded Zicsr instruction at a
// time from execute, issues a read strobe and/or one write-type strobe to
// the CSR file, and hands the old CSR value back for rd writeback.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          RO_CHECK = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_funct3,
  input  logic [11:0]     i_req_adr,
  input  logic [XLEN-1:0] i_req_rs1_val,
  input  logic [4:0]      i_req_uimm,
  input  logic [4:0]      i_req_rd,
  output logic            o_csr_rd,
  output logic            o_csr_wr,
  output logic            o_csr_set,
  output logic            o_csr_clr,
  output logic [11:0]     o_csr_adr,
  output logic [XLEN-1:0] o_csr_wr_data,
  input  logic [XLEN-1:0] i_csr_rd_data,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [4:0]      o_rsp_rd,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_we,
  output logic            o_rsp_illegal
);

  csr_state_e      state_q, state_d;
  csr_op_e         op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            do_read_q, do_read_d;
  logic            do_write_q, do_write_d;
  logic            illegal_q, illegal_d;
  logic [11:0]     adr_q, adr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;

  csr_decode_t     dec;
  logic [XLEN-1:0] operand;

  csr_access_decode #(
    .RO_CHECK (RO_CHECK)
  ) u_decode (
    .funct3_op_i (i_req_funct3[1:0]),
    .adr_i       (i_req_adr),
    .uimm_i      (i_req_uimm),
    .rd_i        (i_req_rd),
    .dec_o       (dec)
  );

  // Immediate forms use the rs1 field itself, zero-extended
  assign operand = i_req_funct3[2] ? {{(XLEN-5){1'b0}}, i_req_uimm} : i_req_rs1_val;

  // Next-state and capture logic. The CSR address and write data are only
  // reloaded for legal accesses so the CSR bus never moves without a strobe.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    do_read_d  = do_read_q;
    do_write_d = do_write_q;
    illegal_d  = illegal_q;
    adr_d      = adr_q;
    wr_data_d  = wr_data_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          op_d       = dec.op;
          rd_d       = i_req_rd;
          do_read_d  = dec.do_read;
          do_write_d = dec.do_write;
          illegal_d  = dec.illegal;
          rsp_data_d = '0;
          if (dec.illegal) begin
            state_d = ST_RESP;
          end else begin
            adr_d     = i_req_adr;
            wr_data_d = operand;
            state_d   = dec.do_read ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_READ: begin
        rsp_data_d = i_csr_rd_data;
        state_d    = do_write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured request; reset aborts any access in flight
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ILLEGAL;
      rd_q       <= '0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      adr_q      <= '0;
      wr_data_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      do_read_q  <= do_read_d;
      do_write_q <= do_write_d;
      illegal_q  <= illegal_d;
      adr_q      <= adr_d;
      wr_data_q  <= wr_data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Strobes come straight from the state so each lasts exactly one cycle
  always_comb begin
    o_csr_rd  = 1'b0;
    o_csr_wr  = 1'b0;
    o_csr_set = 1'b0;
    o_csr_clr = 1'b0;
    unique case (state_q)
      ST_READ: o_csr_rd = 1'b1;
      ST_WRITE: begin
        unique case (op_q)
          OP_RW:   o_csr_wr  = 1'b1;
          OP_RS:   o_csr_set = 1'b1;
          OP_RC:   o_csr_clr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign o_req_ready   = (state_q == ST_IDLE);
  assign o_rsp_valid   = (state_q == ST_RESP);
  assign o_csr_adr     = adr_q;
  assign o_csr_wr_data = wr_data_q;

  // Response fields read as zero whenever no response is being offered
  assign o_rsp_rd      = o_rsp_valid ? rd_q : 5'd0;
  assign o_rsp_data    = o_rsp_valid ? rsp_data_q : '0;
  assign o_rsp_we      = o_rsp_valid && do_read_q && !illegal_q && (rd_q != 5'd0);
  assign o_rsp_illegal = o_rsp_valid && illegal_q;

  // The CSR file relies on never seeing two strobes in the same cycle
  a_strobe_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn)
    $onehot0({o_csr_rd, o_csr_wr, o_csr_set, o_csr_clr}));

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: a small CSR file model reacts to
// the strobes, a scoreboard holds the expected response for each request.
module tb_csr_access_unit;
  import csr_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            reqValid = 1'b0;
  logic            reqReady;
  logic [2:0]      reqFunct3 = '0;
  logic [11:0]     reqAdr = '0;
  logic [XLEN-1:0] reqRs1Val = '0;
  logic [4:0]      reqUimm = '0;
  logic [4:0]      reqRd = '0;
  logic            csrRd, csrWr, csrSet, csrClr;
  logic [11:0]     csrAdr;
  logic [XLEN-1:0] csrWrData;
  logic [XLEN-1:0] csrRdData;
  logic            rspValid;
  logic            rspReady = 1'b0;
  logic [4:0]      rspRd;
  logic [XLEN-1:0] rspData;
  logic            rspWe;
  logic            rspIllegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(XLEN), .RO_CHECK(1'b1)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_req_valid   (reqValid),
    .o_req_ready   (reqReady),
    .i_req_funct3  (reqFunct3),
    .i_req_adr     (reqAdr),
    .i_req_rs1_val (reqRs1Val),
    .i_req_uimm    (reqUimm),
    .i_req_rd      (reqRd),
    .o_csr_rd      (csrRd),
    .o_csr_wr      (csrWr),
    .o_csr_set     (csrSet),
    .o_csr_clr     (csrClr),
    .o_csr_adr     (csrAdr),
    .o_csr_wr_data (csrWrData),
    .i_csr_rd_data (csrRdData),
    .o_rsp_valid   (rspValid),
    .i_rsp_ready   (rspReady),
    .o_rsp_rd      (rspRd),
    .o_rsp_data    (rspData),
    .o_rsp_we      (rspWe),
    .o_rsp_illegal (rspIllegal)
  );

  // CSR file model: combinational read, strobes take effect on the clock
  bit   [XLEN-1:0] csrMem [0:4095];
  logic            preloadEn = 1'b0;
  logic [11:0]     preloadAdr = '0;
  logic [XLEN-1:0] preloadVal = '0;

  assign csrRdData = csrMem[csrAdr];

  always @(posedge clk) begin
    if (preloadEn)   csrMem[preloadAdr] <= preloadVal;
    else if (csrWr)  csrMem[csrAdr] <= csrWrData;
    else if (csrSet) csrMem[csrAdr] <= csrMem[csrAdr] | csrWrData;
    else if (csrClr) csrMem[csrAdr] <= csrMem[csrAdr] & ~csrWrData;
  end

  // Strobe monitor: running totals, sampled away from the active edge
  int              rdStrobes = 0, wrStrobes = 0, setStrobes = 0, clrStrobes = 0;
  int              multiStrobes = 0;
  logic [XLEN-1:0] lastWrData = '0;
  logic [11:0]     lastStrobeAdr = '0;

  always @(negedge clk) begin
    if (csrRd)  rdStrobes++;
    if (csrWr)  wrStrobes++;
    if (csrSet) setStrobes++;
    if (csrClr) clrStrobes++;
    if ((int'(csrRd) + int'(csrWr) + int'(csrSet) + int'(csrClr)) > 1) multiStrobes++;
    if (csrWr || csrSet || csrClr) lastWrData = csrWrData;
    if (csrRd || csrWr || csrSet || csrClr) lastStrobeAdr = csrAdr;
  end

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            we;
    logic            ill;
    int              lat;
    int              nRd, nWr, nSet, nClr;
    logic [XLEN-1:0] wrData;
    logic [11:0]     adr;
  } expRsp_t;

  expRsp_t scoreQ[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic preloadCsr(input logic [11:0] adr, input logic [XLEN-1:0] val);
    @(negedge clk);
    preloadAdr = adr;
    preloadVal = val;
    preloadEn  = 1'b1;
    @(posedge clk);
    #1 preloadEn = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".reqReady"}, 64'(reqReady), 64'(1));
    checkOutput({tag, ".rspValid"}, 64'(rspValid), 64'(0));
    checkOutput({tag, ".strobes"}, 64'({csrRd, csrWr, csrSet, csrClr}), 64'(0));
    checkOutput({tag, ".csrAdr"}, 64'(csrAdr), 64'(0));
    checkOutput({tag, ".csrWrData"}, 64'(csrWrData), 64'(0));
    checkOutput({tag, ".rspFields"}, 64'({rspRd, rspData, rspWe, rspIllegal}), 64'(0));
  endtask

  // Drive one request, predict its response from the instruction rules and
  // the CSR model, then compare when the DUT offers the result
  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] adr,
                               input logic [XLEN-1:0] rs1, input logic [4:0] uimm,
                               input logic [4:0] rd, input int holdCycles);
    expRsp_t e;
    logic [1:0] op;
    logic doRd, doWr, ill;
    int snapRd, snapWr, snapSet, snapClr;
    int lat, waitCnt;
    bit seen;

    op   = f3[1:0];
    doRd = !((op == 2'b01) && (rd == 5'd0));
    doWr = (op == 2'b01) || (uimm != 5'd0);
    ill  = (op == 2'b00) || ((adr[11:10] == 2'b11) && doWr);
    e.rd     = rd;
    e.ill    = ill;
    e.we     = doRd && !ill && (rd != 5'd0);
    e.data   = (doRd && !ill) ? csrMem[adr] : '0;
    e.lat    = ill ? 1 : (1 + int'(doRd) + int'(doWr));
    e.nRd    = (!ill && doRd) ? 1 : 0;
    e.nWr    = (!ill && doWr && op == 2'b01) ? 1 : 0;
    e.nSet   = (!ill && doWr && op == 2'b10) ? 1 : 0;
    e.nClr   = (!ill && doWr && op == 2'b11) ? 1 : 0;
    e.wrData = f3[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1;
    e.adr    = adr;
    scoreQ.push_back(e);

    @(negedge clk);
    reqFunct3 = f3;
    reqAdr    = adr;
    reqRs1Val = rs1;
    reqUimm   = uimm;
    reqRd     = rd;
    reqValid  = 1'b1;
    waitCnt = 0;
    while (!reqReady && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("reqReadyBeforeAccept", 64'(reqReady), 64'(1));
    snapRd = rdStrobes; snapWr = wrStrobes; snapSet = setStrobes; snapClr = clrStrobes;
    @(posedge clk);
    #1 reqValid = 1'b0;

    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      checkOutput("reqReadyLowInFlight", 64'(reqReady), 64'(rspValid ? 0 : (c < 1 ? 1 : 0)));
      if (rspValid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checkOutput("rspValidSeen", 64'(seen), 64'(1));

    e = scoreQ.pop_front();
    checkOutput("latency", 64'(lat), 64'(e.lat));
    for (int h = 0; h <= holdCycles; h++) begin
      if (h > 0) @(negedge clk);
      checkOutput("rspValidHeld", 64'(rspValid), 64'(1));
      checkOutput("rspRd", 64'(rspRd), 64'(e.rd));
      checkOutput("rspData", 64'(rspData), 64'(e.data));
      checkOutput("rspWe", 64'(rspWe), 64'(e.we));
      checkOutput("rspIllegal", 64'(rspIllegal), 64'(e.ill));
    end

    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
    checkOutput("rdStrobes", 64'(rdStrobes - snapRd), 64'(e.nRd));
    checkOutput("wrStrobes", 64'(wrStrobes - snapWr), 64'(e.nWr));
    checkOutput("setStrobes", 64'(setStrobes - snapSet), 64'(e.nSet));
    checkOutput("clrStrobes", 64'(clrStrobes - snapClr), 64'(e.nClr));
    if ((e.nWr + e.nSet + e.nClr) > 0) checkOutput("csrWrData", 64'(lastWrData), 64'(e.wrData));
    if ((e.nRd + e.nWr + e.nSet + e.nClr) > 0) checkOutput("csrAdr", 64'(lastStrobeAdr), 64'(e.adr));
    @(negedge clk);
    checkOutput("rspValidDropped", 64'(rspValid), 64'(0));
    checkOutput("reqReadyReturned", 64'(reqReady), 64'(1));
  endtask

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snapWr;

    #2;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkResetOutputs("afterRelease");

    // CSRRW with read and write
    preloadCsr(12'h200, 32'h0000_0011);
    applyStimulus(CSRRW, 12'h200, 32'hDEAD_BEEF, 5'd7, 5'd5, 0);
    checkOutput("csr200AfterRW", 64'(csrMem[12'h200]), 64'(32'hDEAD_BEEF));

    // CSRRS with rs1=x0: read only
    preloadCsr(12'h800, 32'h0000_00A5);
    applyStimulus(CSRRS, 12'h800, 32'hFFFF_FFFF, 5'd0, 5'd3, 0);
    checkOutput("csr800Unchanged", 64'(csrMem[12'h800]), 64'(32'h0000_00A5));

    // CSRRCI clears the low nibble
    preloadCsr(12'h800, 32'h0000_00FF);
    applyStimulus(CSRRCI, 12'h800, 32'h0, 5'h0F, 5'd7, 0);
    checkOutput("csr800AfterRCI", 64'(csrMem[12'h800]), 64'(32'h0000_00F0));

    // CSRRW into x0: write only
    applyStimulus(CSRRW, 12'h200, 32'h0000_1234, 5'd2, 5'd0, 0);
    checkOutput("csr200AfterRWx0", 64'(csrMem[12'h200]), 64'(32'h0000_1234));

    // Register-operand set and clear, immediate write
    preloadCsr(12'h340, 32'h0000_0100);
    applyStimulus(CSRRS, 12'h340, 32'h0000_00F0, 5'd9, 5'd9, 0);
    checkOutput("csr340AfterRS", 64'(csrMem[12'h340]), 64'(32'h0000_01F0));
    preloadCsr(12'h342, 32'h1234_5678);
    applyStimulus(CSRRC, 12'h342, 32'hFFFF_0000, 5'd4, 5'd11, 0);
    checkOutput("csr342AfterRC", 64'(csrMem[12'h342]), 64'(32'h0000_5678));
    applyStimulus(CSRRWI, 12'h341, 32'hFFFF_FFFF, 5'h1A, 5'd10, 0);
    checkOutput("csr341AfterRWI", 64'(csrMem[12'h341]), 64'(32'h0000_001A));

    // Illegal: reserved funct3 and a write to a read-only CSR
    applyStimulus(3'b100, 12'h300, 32'h0, 5'd1, 5'd1, 0);
    preloadCsr(12'hF00, 32'hCAFE_0001);
    applyStimulus(CSRRW, 12'hF00, 32'h5555_5555, 5'd1, 5'd4, 0);
    checkOutput("csrF00Untouched", 64'(csrMem[12'hF00]), 64'(32'hCAFE_0001));

    // Reading a read-only CSR is legal; hold off the response for 5 cycles
    applyStimulus(CSRRS, 12'hF00, 32'h0, 5'd0, 5'd6, 5);

    // Reset in the middle of a READ must suppress the following write
    preloadCsr(12'h305, 32'h0000_0055);
    @(negedge clk);
    reqFunct3 = CSRRW;
    reqAdr    = 12'h305;
    reqRs1Val = 32'h0000_0077;
    reqUimm   = 5'd8;
    reqRd     = 5'd8;
    reqValid  = 1'b1;
    checkOutput("resetTest.reqReady", 64'(reqReady), 64'(1));
    snapWr = wrStrobes;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    checkOutput("resetTest.inRead", 64'(csrRd), 64'(1));
    rstn = 1'b0;
    #1;
    checkResetOutputs("midReadReset");
    repeat (3) @(negedge clk);
    checkResetOutputs("resetHeld");
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("afterMidReset");
    checkOutput("resetTest.noWrStrobe", 64'(wrStrobes - snapWr), 64'(0));
    checkOutput("resetTest.csr305", 64'(csrMem[12'h305]), 64'(32'h0000_0055));

    // Normal operation resumes after the abort
    applyStimulus(CSRRSI, 12'h305, 32'h0, 5'h02, 5'd12, 0);
    checkOutput("csr305AfterRSI", 64'(csrMem[12'h305]), 64'(32'h0000_0057));

    checkOutput("multiStrobeCycles", 64'(multiStrobes), 64'(0));
    checkOutput("scoreboardEmpty", 64'(scoreQ.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
